alu_arbiter: RTL and testbench

Shares one combinational ALU datapath (add, sub, multiply, bitwise, compare and shift) among `N_REQ` requesters. Arbitration is round-robin, and each operation runs as a three-phase sequence: grant, execute, respond. The result, requester ID and error flag are registered and held on a single response channel until the consumer accepts them. It sits between multiple datapath clients and the shared arithmetic resource, replacing per-client ALU instances.

---
 rtl/alu_arb_pkg.sv | 32 +++
 rtl/alu_core.sv | 48 ++++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter and its combinational core.
//   OP_W        : opcode width
//   alu_op_t    : opcode encoding (14 and 15 are illegal)
//   arb_state_t : grant / execute / respond sequence
package alu_arb_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_GT  = 4'd7,
        OP_EQ  = 4'd8,
        OP_LT  = 4'd9,
        OP_GTE = 4'd10,
        OP_LTE = 4'd11,
        OP_SHL = 4'd12,
        OP_SHR = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by the schedulers.
//   op    : opcode (alu_op_t encoding)
//   left  : left operand
//   right : right operand or shift amount
//   out   : result (0 on an illegal op)
//   err   : opcode illegal or compiled out
// Build option: ALU_ARB_MULT_EN adds the multiplier; without it op 2 is illegal.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             err
);

    // Shift amounts of WIDTH or more flush the operand completely
    logic shift_ovf;
    assign shift_ovf = (right >= WIDTH'(WIDTH));

    always_comb begin
        out = '0;
        err = 1'b0;
        case (op)
            OP_ADD: out = left + right;
            OP_SUB: out = left - right;
`ifdef ALU_ARB_MULT_EN
            OP_MUL: out = left * right;
`endif
            OP_AND: out = left & right;
            OP_OR:  out = left | right;
            OP_XOR: out = left ^ right;
            OP_NOT: out = ~left;
            OP_GT:  out = WIDTH'(left >  right);
            OP_EQ:  out = WIDTH'(left == right);
            OP_LT:  out = WIDTH'(left <  right);
            OP_GTE: out = WIDTH'(left >= right);
            OP_LTE: out = WIDTH'(left <= right);
            OP_SHL: out = shift_ovf ? '0 : (left << right);
            OP_SHR: out = shift_ovf ? '0 : (left >> right);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core among N_REQ requesters.
// Each operation runs grant (IDLE) -> execute (EXEC) -> respond (RESP).
//   clk, reset_n          : clock, async active-low reset
//   req_valid / req_ready : per-requester handshake (req_ready is combinational)
//   req_op/left/right     : packed per-requester opcode and operands
//   resp_valid/ready      : result handshake
//   resp_data/id/err      : registered result, requester index, error flag
// Build option: ALU_ARB_MULT_EN (passed through to alu_core).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    input  logic [N_REQ*WIDTH-1:0]   req_left,
    input  logic [N_REQ*WIDTH-1:0]   req_right,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_err
);

    arb_state_t        state, state_d;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  l_q, l_d, r_q, r_d;
    logic [WIDTH-1:0]  resp_data_d;
    logic [ID_W-1:0]   resp_id_d;
    logic              resp_err_d, resp_valid_d;

    logic [OP_W-1:0]   op_arr  [N_REQ];
    logic [WIDTH-1:0]  l_arr   [N_REQ];
    logic [WIDTH-1:0]  r_arr   [N_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx, cand;
    logic [WIDTH-1:0]  alu_out;
    logic              alu_err;

    // Unpack the per-requester buses
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[i*OP_W +: OP_W];
        assign l_arr[i]  = req_left[i*WIDTH +: WIDTH];
        assign r_arr[i]  = req_right[i*WIDTH +: WIDTH];
    end

    // Cyclic search for the first valid requester starting at rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op    (op_q),
        .left  (l_q),
        .right (r_q),
        .out   (alu_out),
        .err   (alu_err)
    );

    // Next-state and datapath load decisions
    always_comb begin
        state_d      = state;
        rr_ptr_d     = rr_ptr;
        op_d         = op_q;
        l_d          = l_q;
        r_d          = r_q;
        resp_data_d  = resp_data;
        resp_id_d    = resp_id;
        resp_err_d   = resp_err;
        resp_valid_d = resp_valid;
        req_ready    = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    // Held low during reset even though the state reads IDLE
                    req_ready = reset_n ? (N_REQ'(1) << grant_idx) : '0;
                    op_d      = op_arr[grant_idx];
                    l_d       = l_arr[grant_idx];
                    r_d       = r_arr[grant_idx];
                    resp_id_d = grant_idx;
                    rr_ptr_d  = ID_W'((32'(grant_idx) + 32'd1) % N_REQ);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = alu_out;
                resp_err_d   = alu_err;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_q       <= '0;
            l_q        <= '0;
            r_q        <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            op_q       <= op_d;
            l_q        <= l_d;
            r_q        <= r_d;
            resp_data  <= resp_data_d;
            resp_id    <= resp_id_d;
            resp_err   <= resp_err_d;
            resp_valid <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic
// compared against a behavioural model of the ALU and the round-robin rule.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*OP_W-1:0]   req_op;
    logic [N_REQ*WIDTH-1:0]  req_left;
    logic [N_REQ*WIDTH-1:0]  req_right;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [WIDTH-1:0]        resp_data;
    logic [ID_W-1:0]         resp_id;
    logic                    resp_err;

    logic [3:0]        tb_op [N_REQ];
    logic [WIDTH-1:0]  tb_l  [N_REQ];
    logic [WIDTH-1:0]  tb_r  [N_REQ];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ptr_m   = 0;
    int grant_cyc = 0;
    int last_g  = 0;
    logic [WIDTH-1:0] last_data;
    logic             last_err;

    alu_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_left   (req_left),
        .req_right  (req_right),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_op[i*OP_W +: OP_W]    = tb_op[i];
            req_left[i*WIDTH +: WIDTH]  = tb_l[i];
            req_right[i*WIDTH +: WIDTH] = tb_r[i];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU in plain 64-bit arithmetic, truncated to 32 bits
    function automatic void ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] d, output logic e);
        longint unsigned x, y, res;
        x = 64'(a);
        y = 64'(b);
        res = 0;
        e = 1'b0;
        case (int'(op))
            0:  res = x + y;
            1:  res = x - y;
`ifdef ALU_ARB_MULT_EN
            2:  res = x * y;
`else
            2:  e = 1'b1;
`endif
            3:  res = x & y;
            4:  res = x | y;
            5:  res = x ^ y;
            6:  res = ~x;
            7:  res = (x >  y) ? 1 : 0;
            8:  res = (x == y) ? 1 : 0;
            9:  res = (x <  y) ? 1 : 0;
            10: res = (x >= y) ? 1 : 0;
            11: res = (x <= y) ? 1 : 0;
            12: res = (y >= 32) ? 0 : (x << y);
            13: res = (y >= 32) ? 0 : (x >> y);
            default: e = 1'b1;
        endcase
        d = e ? '0 : res[31:0];
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] m, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (m[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        tb_op[i] = op;
        tb_l[i]  = a;
        tb_r[i]  = b;
    endtask

    // One full transaction; entered and left at posedge+1 with the DUT in IDLE
    task automatic do_txn(input logic [N_REQ-1:0] mask, input int stall, input string tag);
        int g;
        logic [WIDTH-1:0] ed;
        logic ee;
        logic [N_REQ-1:0] oh;
        req_valid = mask;
        #1;
        if (mask == '0) begin
            check({tag, ":no_grant"}, 64'(req_ready), 64'(0));
            @(posedge clk); #1;
            check({tag, ":no_resp"}, 64'(resp_valid), 64'(0));
            return;
        end
        g  = rr_pick(mask, ptr_m);
        oh = N_REQ'(1) << g;
        ref_alu(tb_op[g], tb_l[g], tb_r[g], ed, ee);
        check({tag, ":grant"}, 64'(req_ready), 64'(oh));
        grant_cyc = cyc;
        last_g    = g;
        @(posedge clk); #1;
        check({tag, ":exec_ready"}, 64'(req_ready), 64'(0));
        check({tag, ":exec_valid"}, 64'(resp_valid), 64'(0));
        resp_ready = (stall == 0);
        @(posedge clk); #1;
        check({tag, ":valid"}, 64'(resp_valid), 64'(1));
        check({tag, ":data"}, 64'(resp_data), 64'(ed));
        check({tag, ":id"}, 64'(resp_id), 64'(g));
        check({tag, ":err"}, 64'(resp_err), 64'(ee));
        check({tag, ":resp_ready"}, 64'(req_ready), 64'(0));
        for (int s = 1; s <= stall; s++) begin
            @(posedge clk); #1;
            check({tag, ":stall_valid"}, 64'(resp_valid), 64'(1));
            check({tag, ":stall_data"}, 64'(resp_data), 64'(ed));
            check({tag, ":stall_id"}, 64'(resp_id), 64'(g));
            check({tag, ":stall_err"}, 64'(resp_err), 64'(ee));
            check({tag, ":stall_req_ready"}, 64'(req_ready), 64'(0));
            if (s == stall) resp_ready = 1'b1;
        end
        last_data = resp_data;
        last_err  = resp_err;
        @(posedge clk); #1;
        check({tag, ":done_valid"}, 64'(resp_valid), 64'(0));
        ptr_m = (g + 1) % N_REQ;
    endtask

    initial begin
        int prev;
        logic [N_REQ-1:0] m;
        reset_n    = 1'b0;
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int i = 0; i < N_REQ; i++) set_req(i, 4'd0, '0, '0);

        // Reset state
        #12;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_valid", 64'(resp_valid), 64'(0));
        check("rst_data", 64'(resp_data), 64'(0));
        check("rst_id", 64'(resp_id), 64'(0));
        check("rst_err", 64'(resp_err), 64'(0));
        req_valid = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        ptr_m = 0;

        // Contention: all valid, SUB 10-i, grants 0,1,2,3,0 every 3 cycles
        for (int i = 0; i < N_REQ; i++) set_req(i, 4'd1, 32'd10, 32'(i));
        prev = 0;
        for (int t = 0; t < 5; t++) begin
            do_txn(4'hF, 0, "contend");
            check("contend_order", 64'(last_g), 64'(t % 4));
            check("contend_result", 64'(last_data), 64'(10 - (t % 4)));
            if (t > 0) check("contend_gap", 64'(grant_cyc - prev), 64'(3));
            prev = grant_cyc;
        end
        req_valid = '0;

        // Single request: ADD 5+7
        set_req(0, 4'd0, 32'd5, 32'd7);
        do_txn(4'b0001, 0, "single");
        check("single_data", 64'(last_data), 64'(12));

        // Backpressure on requester 2, then regrant one cycle after handshake
        set_req(2, 4'd5, 32'hA5A5_0F0F, 32'h0FF0_1234);
        do_txn(4'b0100, 5, "bp");
        prev = grant_cyc;
        do_txn(4'b0100, 0, "bp_regrant");
        check("bp_regrant_gap", 64'(grant_cyc - prev), 64'(8));

        // Width edges and illegal ops on requester 1
        set_req(1, 4'd0, 32'hFFFF_FFFF, 32'd1);  do_txn(4'b0010, 0, "add_wrap");
        check("add_wrap_lit", 64'(last_data), 64'(0));
        set_req(1, 4'd1, 32'd0, 32'd1);           do_txn(4'b0010, 0, "sub_wrap");
        check("sub_wrap_lit", 64'(last_data), 64'(32'hFFFF_FFFF));
        set_req(1, 4'd12, 32'd1, 32'd32);         do_txn(4'b0010, 0, "shl32");
        check("shl32_lit", 64'(last_data), 64'(0));
        set_req(1, 4'd7, 32'd3, 32'd2);           do_txn(4'b0010, 0, "gt");
        check("gt_lit", 64'(last_data), 64'(1));
        set_req(1, 4'd2, 32'h10000, 32'h10000);   do_txn(4'b0010, 0, "mul");
        check("mul_lit", 64'(last_data), 64'(0));
`ifdef ALU_ARB_MULT_EN
        check("mul_err_lit", 64'(last_err), 64'(0));
`else
        check("mul_err_lit", 64'(last_err), 64'(1));
`endif
        set_req(1, 4'd15, 32'h1234, 32'h5678);    do_txn(4'b0010, 0, "ill15");
        check("ill15_err_lit", 64'(last_err), 64'(1));
        check("ill15_data_lit", 64'(last_data), 64'(0));

        // Reset during EXEC discards the operation and clears the pointer
        req_valid = 4'b0010;
        set_req(1, 4'd0, 32'd1, 32'd1);
        #1;
        check("rstx_grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rstx_req_ready", 64'(req_ready), 64'(0));
        check("rstx_valid0", 64'(resp_valid), 64'(0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rstx_valid", 64'(resp_valid), 64'(0));
            check("rstx_id", 64'(resp_id), 64'(0));
        end
        reset_n = 1'b1;
        ptr_m = 0;
        do_txn(4'hF, 0, "post_rst");
        check("post_rst_first", 64'(last_g), 64'(0));

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N_REQ; i++) begin
                tb_op[i] = 4'($urandom_range(0, 15));
                tb_l[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom());
                tb_r[i]  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom());
            end
            m = N_REQ'($urandom_range(0, 15));
            do_txn(m, int'($urandom_range(0, 3)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
